apb_cfg_master: RTL and testbench
=================================

Name: apb_cfg_master

Overview:
- APB requester that drives the configuration-memory APB slave port: psel/penable/pwrite/paddr/pwdata out, prdata/pready/pslverr in.
- Converts a valid/ready command stream from the system controller into single APB transfers.
- Returns read data and status on a valid/ready response channel.
- Range-checks addresses and aborts stalled transfers on timeout.

Parameters:
- ADDR_W, 16, APB address width.
- DATA_W, 32, APB data width.
- ADDR_LIMIT, 64, word depth of the target memory; cmd_addr >= ADDR_LIMIT is rejected with no bus access.
- TIMEOUT, 255, maximum ACCESS cycles with pready low before abort (1..65535).

Ports:
- pclk  in  1  single clock for all logic.
- prstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  word address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  pslverr, range error or timeout.
- rsp_timeout  out  1  error cause was timeout.
- busy  out  1  state != IDLE.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  slave ready; tie high for zero-wait slaves.
- pslverr  in  1  slave error, sampled with pready.

Behaviour:
- Reset (prstn low, asynchronous): state=IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy, wait counter all 0. cmd_ready is forced 0 while prstn is low.
- States: IDLE, SETUP, ACCESS, RESP. All outputs are registered except cmd_ready = (state==IDLE) & prstn.
- IDLE:
  - cmd_valid & cmd_ready latches write/addr/wdata.
  - If cmd_addr >= ADDR_LIMIT: go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0; psel never asserts.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0; paddr/pwrite/pwdata = latched values; clear wait counter. Next state ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata stable.
  - pready=1: complete the transfer.
    - rsp_rdata = prdata if read and pslverr=0, else 0.
    - rsp_err = pslverr; rsp_timeout = 0.
    - Next cycle: psel=0, penable=0, state RESP.
  - pready=0: increment wait counter. When the counter reaches TIMEOUT (TIMEOUT consecutive low-pready ACCESS cycles):
    - Drop psel/penable.
    - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - Go to RESP.
- RESP: rsp_valid=1; rsp_rdata/rsp_err/rsp_timeout held stable until rsp_valid & rsp_ready. Then rsp_valid=0 and state IDLE. No new command is accepted until RESP drains.
- Latency with pready=1:
  - Accept at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3.
  - With rsp_ready tied high, back-to-back throughput is 1 transfer per 4 cycles.
- paddr/pwrite/pwdata keep their last values after a transfer; they change only on entry to SETUP. pwdata is 0 for reads.
- A second command presented during busy is held off (cmd_ready=0) and must not be lost or reordered.
- pslverr is ignored when pready=0 or psel=0.
- Reset mid-transfer: bus outputs drop to 0 immediately (asynchronous); any in-flight command and pending response are discarded.
- Wait counter width is clog2(TIMEOUT+1) bits, saturating; it never wraps.

Test Plan:
- Write then read:
  - Write addr 5, data 0xDEADBEEF, pready=1 → SETUP psel=1/penable=0, ACCESS psel=1/penable=1/pwrite=1/paddr=5/pwdata=0xDEADBEEF; rsp_valid on cycle 3 with rsp_err=0.
  - Then read addr 5 with slave returning 0xDEADBEEF → rsp_rdata=0xDEADBEEF.
- Range error: read addr 64 (ADDR_LIMIT=64) → psel stays 0 for the whole command; rsp_valid with rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Wait states and timeout:
  - pready low for 3 ACCESS cycles, then high with prdata=0x1234 → penable held 4 cycles, rsp_rdata=0x1234, rsp_err=0.
  - TIMEOUT=8 with pready stuck low → abort after 8 ACCESS cycles, rsp_err=1, rsp_timeout=1.
- Slave error: read addr 2 with pslverr=1 and pready=1 → rsp_err=1, rsp_timeout=0, rsp_rdata=0 although prdata=0xFFFFFFFF.
- Response backpressure:
  - rsp_ready low for 5 cycles → rsp_valid and rsp_rdata stable, cmd_ready=0 throughout, psel=0.
  - A queued second command (write addr 7) starts SETUP only after the response handshake.
- Reset mid-ACCESS: prstn low during penable=1 → psel/penable/rsp_valid become 0 without a clock edge.
  - After release, cmd_ready=1; the next command (read addr 1) completes normally.

Source files
------------

// File: rtl/apb_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_cfg_master
// Description : APB requester for the configuration-memory slave port.
//               Turns a valid/ready command stream into single APB transfers
//               and returns read data and status on a valid/ready response
//               channel. Out-of-range addresses are rejected without touching
//               the bus; transfers stalled by pready are aborted on timeout.
// Ports       : pclk/prstn            clock, async active-low reset
//               cmd_*                 command channel (valid/ready)
//               rsp_*                 response channel (valid/ready)
//               busy                  high whenever a command is in flight
//               psel..pwdata, prdata,
//               pready, pslverr       APB requester interface
// Revision    : 1.0 - initial release
// ============================================================================
module apb_cfg_master #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int ADDR_LIMIT = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic              pclk,
  input  logic              prstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // One extra bit so a limit equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]  c_addr_limit = (ADDR_W + 1)'(ADDR_LIMIT);
  localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_cnt_max    = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

  logic                w_in_range;
  logic [CNT_W-1:0]    w_cnt_inc;

  assign w_in_range = ({1'b0, cmd_addr} < c_addr_limit);
  // Saturating increment: the counter never wraps back to zero.
  assign w_cnt_inc  = (wait_cnt_q == c_cnt_max) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (w_in_range) begin
            // Bus fields are loaded here so they appear together with psel
            // in SETUP and otherwise keep their previous values.
            state_d  = S_SETUP;
            psel_d   = 1'b1;
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_write ? cmd_wdata : '0;
          end else begin
            state_d       = S_RESP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
          end
        end
      end

      S_SETUP: begin
        state_d    = S_ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end

      S_ACCESS: begin
        if (pready) begin
          state_d       = S_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!pwrite_q && !pslverr) ? prdata : '0;
        end else begin
          wait_cnt_d = w_cnt_inc;
          // This low-pready cycle is the TIMEOUT-th one: abort the transfer.
          if (wait_cnt_q == c_cnt_last) begin
            state_d       = S_RESP;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state_q       <= S_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // Only combinational output; gated by reset so nothing is accepted in reset.
  assign cmd_ready   = (state_q == S_IDLE) & prstn;

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_cfg_master
// Description : Self-checking bench for apb_cfg_master. A transaction-level
//               model predicts, per accepted command, the bus window, the
//               response latency and the response contents; a compare
//               process checks the DUT against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_cfg_master;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LIM = 64;
  localparam int TO  = 8;

  logic          pclk = 1'b0;
  logic          prstn = 1'b1;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready;
  logic          rsp_valid, rsp_err, rsp_timeout, busy;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0, pslverr = 1'b0;

  always #5 pclk = ~pclk;

  apb_cfg_master #(.ADDR_W(AW), .DATA_W(DW), .ADDR_LIMIT(LIM), .TIMEOUT(TO)) dut (
    .pclk(pclk), .prstn(prstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    bit          wr;
    int          addr;
    logic [31:0] wdata;
    int          waits;     // low-pready ACCESS cycles the slave inserts
    bit          serr;
    bit          in_range;
    int          acc_end;   // last cycle (after accept) with psel high
    int          lat;       // first cycle (after accept) with rsp_valid
    logic [31:0] rdata;
    bit          err;
    bit          tmo;
  } xact_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state
  logic [31:0] model_mem [64];
  logic [31:0] slave_mem [64];
  xact_t       cur;
  bit          outstanding = 0;
  int          age = 0;
  bit          chk_en = 0;
  logic [15:0] last_addr = '0;
  bit          last_wr = 0;
  logic [31:0] last_wd = '0;
  bit          rsp_seen = 0;
  int          last_lat = 0;
  logic [31:0] last_rdata = '0;
  bit          last_err = 0, last_to = 0;
  int          rsp_count = 0, n_sent = 0;
  bit          e_psel, e_pen, e_rv;

  // Driver side-band describing how the slave should treat the next command
  int          drv_waits = 0;
  bit          drv_serr = 0;
  bit          rsp_hold = 0;

  // -------------------------------------------------------------- compare
  always @(negedge pclk) begin
    if (chk_en && prstn) begin
      e_psel = outstanding && cur.in_range && age >= 1 && age <= cur.acc_end;
      e_pen  = outstanding && cur.in_range && age >= 2 && age <= cur.acc_end;
      e_rv   = outstanding && age >= cur.lat;
      chk("psel",      32'(psel),      32'(e_psel));
      chk("penable",   32'(penable),   32'(e_pen));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("cmd_ready", 32'(cmd_ready), 32'(!outstanding));
      chk("busy",      32'(busy),      32'(outstanding));
      if (e_psel) begin
        last_addr = 16'(cur.addr);
        last_wr   = cur.wr;
        last_wd   = cur.wr ? cur.wdata : 32'd0;
      end
      chk("paddr",  32'(paddr),  32'(last_addr));
      chk("pwrite", 32'(pwrite), 32'(last_wr));
      chk("pwdata", pwdata, last_wd);
      if (e_rv) begin
        chk("rsp_rdata",   rsp_rdata,         cur.rdata);
        chk("rsp_err",     32'(rsp_err),     32'(cur.err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(cur.tmo));
        if (!rsp_seen) begin
          rsp_seen = 1;
          last_lat = age;
        end
      end
      if (outstanding) begin
        if (rsp_valid && rsp_ready) begin
          outstanding = 0;
          last_rdata  = rsp_rdata;
          last_err    = rsp_err;
          last_to     = rsp_timeout;
          rsp_count++;
        end else begin
          age++;
        end
      end else if (cmd_valid && cmd_ready) begin
        cur.wr       = cmd_write;
        cur.addr     = int'(cmd_addr);
        cur.wdata    = cmd_wdata;
        cur.waits    = drv_waits;
        cur.serr     = drv_serr;
        cur.in_range = cur.addr < LIM;
        cur.rdata    = 32'd0;
        cur.tmo      = 0;
        if (!cur.in_range) begin
          cur.acc_end = 0;
          cur.lat     = 1;
          cur.err     = 1;
        end else if (cur.waits >= TO) begin
          cur.acc_end = 1 + TO;
          cur.lat     = 2 + TO;
          cur.err     = 1;
          cur.tmo     = 1;
        end else begin
          cur.acc_end = 2 + cur.waits;
          cur.lat     = 3 + cur.waits;
          cur.err     = cur.serr;
          if (!cur.wr && !cur.serr) cur.rdata = model_mem[6'(cur.addr)];
          if (cur.wr && !cur.serr) model_mem[6'(cur.addr)] = cur.wdata;
        end
        outstanding = 1;
        age         = 1;
        rsp_seen    = 0;
      end
    end
  end

  // -------------------------------------------------------------- APB slave
  int acnt = 0;
  always @(posedge pclk) begin
    #1;
    if (psel && !penable) begin
      acnt    = 0;
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      prdata  = $urandom;
    end else if (psel && penable) begin
      if (acnt < cur.waits) begin
        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end else begin
        pready  = 1'b1;
        pslverr = cur.serr;
        if (cur.serr)      prdata = 32'hFFFF_FFFF;
        else if (cur.wr)   prdata = $urandom;
        else               prdata = slave_mem[paddr[5:0]];
        if (cur.wr && !cur.serr) slave_mem[paddr[5:0]] = pwdata;
      end
      acnt++;
    end else begin
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      prdata  = $urandom;
    end
  end

  // -------------------------------------------------------------- rsp_ready
  always @(posedge pclk) begin
    #1;
    rsp_ready = rsp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // -------------------------------------------------------------- tasks
  task automatic send(input bit wr, input int addr, input logic [31:0] wd,
                      input int waits, input bit serr);
    int n;
    @(posedge pclk); #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = 16'(addr);
    cmd_wdata = wd;
    drv_waits = waits;
    drv_serr  = serr;
    n = 0;
    @(negedge pclk);
    while (!cmd_ready && n < 200) begin
      @(negedge pclk);
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    n_sent++;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = 16'($urandom);
    cmd_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((outstanding || cmd_valid) && n < 300) begin
      @(negedge pclk);
      n++;
    end
    chk("drain", 32'(outstanding), 32'd0);
  endtask

  // -------------------------------------------------------------- watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------- main
  initial begin
    int n;
    for (int i = 0; i < 64; i++) begin
      model_mem[i] = $urandom;
      slave_mem[i] = model_mem[i];
    end
    #1 prstn = 1'b0;
    #2;
    chk("rst_psel",      32'(psel),      32'd0);
    chk("rst_penable",   32'(penable),   32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_paddr",     32'(paddr),     32'd0);
    chk("rst_pwdata",    pwdata,         32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    @(negedge pclk); @(negedge pclk); #1;
    prstn  = 1'b1;
    chk_en = 1;

    // Write then read back
    send(1, 5, 32'hDEAD_BEEF, 0, 0); drain();
    chk("wr_lat", 32'(last_lat), 32'd3);
    chk("wr_err", 32'(last_err), 32'd0);
    send(0, 5, $urandom, 0, 0); drain();
    chk("rd_data", last_rdata, 32'hDEAD_BEEF);
    chk("rd_lat",  32'(last_lat), 32'd3);

    // Range error
    send(0, 64, 32'd0, 0, 0); drain();
    chk("range_err",   32'(last_err), 32'd1);
    chk("range_to",    32'(last_to),  32'd0);
    chk("range_rdata", last_rdata,    32'd0);
    chk("range_lat",   32'(last_lat), 32'd1);

    // Three wait states
    slave_mem[9] = 32'h1234;
    model_mem[9] = 32'h1234;
    send(0, 9, 32'd0, 3, 0); drain();
    chk("wait_rdata", last_rdata,    32'h1234);
    chk("wait_err",   32'(last_err), 32'd0);
    chk("wait_lat",   32'(last_lat), 32'd6);

    // Timeout
    send(0, 10, 32'd0, 99, 0); drain();
    chk("tmo_err",   32'(last_err), 32'd1);
    chk("tmo_to",    32'(last_to),  32'd1);
    chk("tmo_rdata", last_rdata,    32'd0);
    chk("tmo_lat",   32'(last_lat), 32'd10);

    // Slave error
    send(0, 2, 32'd0, 0, 1); drain();
    chk("serr_err",   32'(last_err), 32'd1);
    chk("serr_to",    32'(last_to),  32'd0);
    chk("serr_rdata", last_rdata,    32'd0);

    // Response backpressure with a queued write
    rsp_hold = 1;
    send(0, 3, 32'd0, 0, 0);
    fork
      send(1, 7, 32'h0707_0707, 0, 0);
    join_none
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge pclk);
      n++;
    end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    repeat (5) begin
      @(negedge pclk);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_psel",      32'(psel),      32'd0);
    end
    rsp_hold = 0;
    wait fork;
    drain();
    chk("bp_write_mem", slave_mem[7], 32'h0707_0707);

    // Reset in the middle of ACCESS
    send(0, 4, 32'd0, 99, 0);
    n = 0;
    while (!penable && n < 20) begin
      @(negedge pclk);
      n++;
    end
    chk("mid_pen_seen", 32'(penable), 32'd1);
    chk_en = 0;
    #2 prstn = 1'b0;
    #1;
    chk("mid_psel",      32'(psel),      32'd0);
    chk("mid_penable",   32'(penable),   32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_busy",      32'(busy),      32'd0);
    outstanding = 0;
    last_addr   = '0;
    last_wr     = 0;
    last_wd     = '0;
    @(negedge pclk); @(negedge pclk); #1;
    prstn = 1'b1;
    #1;
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk_en    = 1;
    rsp_count = 0;
    n_sent    = 0;
    slave_mem[1] = 32'hA5A5_0001;
    model_mem[1] = 32'hA5A5_0001;
    send(0, 1, 32'd0, 0, 0); drain();
    chk("post_rdata", last_rdata,    32'hA5A5_0001);
    chk("post_err",   32'(last_err), 32'd0);
    chk("post_lat",   32'(last_lat), 32'd3);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      bit          wr, serr;
      int          addr, waits;
      logic [31:0] wd;
      wr    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(64, 65535))
                                          : int'($urandom_range(0, 63));
      waits = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 3));
      serr  = ($urandom_range(0, 5) == 0);
      wd    = $urandom;
      repeat ($urandom_range(0, 2)) @(posedge pclk);
      send(wr, addr, wd, waits, serr);
    end
    drain();
    chk("rsp_count", 32'(rsp_count), 32'(n_sent));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
